// File: rtl/f_nextpc.sv
// Fetch next-PC generator with a direct-mapped BTB and 2-bit direction counters.
// Latency: pc is registered (1 cycle); pc_predicted is combinational from pc and BTB.
// Backpressure: stall holds pc, but a redirect still applies; BTB updates ignore stall.
//
// Ports:
//   clk, rst                   - single clock, asynchronous active-high reset
//   stall                      - hold the fetch PC (downstream not ready)
//   fail_predict, nextpc       - decode redirect request and the resolved next word PC
//   upd_valid/pc/taken/uncond  - resolved branch/JAL training info from decode
//   pc, pc_predicted           - current fetch word PC and its predicted successor
//   stat_branches/mispredicts  - event counters, present only with F_NEXTPC_STATS_EN
module f_nextpc #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fail_predict,
  input  logic [12:0] nextpc,
  input  logic        upd_valid,
  input  logic [12:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_uncond,
  output logic [12:0] pc,
  output logic [12:0] pc_predicted
`ifdef F_NEXTPC_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 13 - IDX_W;

  // BTB storage; only valid and ctr carry reset state.
  logic [N-1:0]     valid_q;
  logic [1:0]       ctr_q [N];
  logic [TAG_W-1:0] tag_q [N];
  logic [12:0]      tgt_q [N];

  // Lookup for the current fetch PC.
  logic [IDX_W-1:0] lk_idx;
  logic             lk_hit;

  assign lk_idx = pc[IDX_W-1:0];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == pc[12:IDX_W]);

  // Counter MSB set means ctr >= 2, i.e. predict taken.
  assign pc_predicted = (lk_hit && ctr_q[lk_idx][1]) ? tgt_q[lk_idx] : pc + 13'd1;

  // Training path.
  logic [IDX_W-1:0] up_idx;
  logic             up_hit;
  logic             ctr_wr;
  logic             alloc_wr;
  logic [1:0]       ctr_nxt;

  assign up_idx = upd_pc[IDX_W-1:0];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == upd_pc[12:IDX_W]);

  // A taken outcome always (re)writes tag/target/valid: on a hit the tag is
  // unchanged, on a miss this is the allocation. A not-taken miss writes nothing.
  assign alloc_wr = upd_valid && upd_taken;
  assign ctr_wr   = upd_valid && (up_hit || upd_taken);

  always_comb begin
    ctr_nxt = ctr_q[up_idx];
    if (up_hit) begin
      if (upd_taken) begin
        if (upd_uncond)
          ctr_nxt = 2'd3;
        else if (ctr_q[up_idx] != 2'd3)
          ctr_nxt = ctr_q[up_idx] + 2'd1;
      end else if (ctr_q[up_idx] != 2'd0) begin
        ctr_nxt = ctr_q[up_idx] - 2'd1;
      end
    end else begin
      ctr_nxt = upd_uncond ? 2'd3 : 2'd2;
    end
  end

  // PC register and reset-bearing BTB state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= 13'd0;
      valid_q <= '0;
      for (int i = 0; i < N; i++) ctr_q[i] <= 2'd1;
    end else begin
      // Redirect wins over stall so a mispredict is never dropped.
      if (fail_predict)
        pc <= nextpc;
      else if (!stall)
        pc <= pc_predicted;

      if (alloc_wr) valid_q[up_idx] <= 1'b1;
      if (ctr_wr)   ctr_q[up_idx]   <= ctr_nxt;
    end
  end

  // Tag/target need no reset; gating on rst keeps an update that coincides
  // with reset from landing.
  always_ff @(posedge clk) begin
    if (!rst && alloc_wr) begin
      tag_q[up_idx] <= upd_pc[12:IDX_W];
      tgt_q[up_idx] <= nextpc;
    end
  end

`ifdef F_NEXTPC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (upd_valid)    stat_branches    <= stat_branches + 32'd1;
      if (fail_predict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
